// File: rtl/lathe_cycle_seq.sv
// Lathe auto/manual cycle sequencer: spindle delay, timed run, batch count.
// A latched estop fault overrides every other input.
module lathe_cycle_seq #(
    parameter int DELAY_TICKS = 150_000_000,
    parameter int RUN_TICKS   = 50_000_000,
    parameter int TMR_W       = 28,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             estop,
    input  logic             auto_mode,
    input  logic             man_mode,
    input  logic             clr_count,
    input  logic [CNT_W-1:0] batch_size,
    output logic             control,
    output logic             busy,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic             batch_done,
    output logic             fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(DELAY_TICKS - 1);
    localparam logic [TMR_W-1:0] RUN_LAST   = TMR_W'(RUN_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           cur, nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             fault_q, fault_nxt;
    logic             start_d;
    logic             inc;

    logic             start_rise, auto_ok, man_ok, batch_hit;
    logic [CNT_W:0]   count_inc;

    assign start_rise = start & ~start_d;
    assign auto_ok    = auto_mode & ~man_mode & ~fault_q;
    assign man_ok     = man_mode & ~auto_mode & ~fault_q;
    // one extra bit so a saturated count still compares as "reached"
    assign count_inc  = {1'b0, count} + (CNT_W+1)'(1);
    assign batch_hit  = (batch_size != '0) &&
                        (count_inc >= {1'b0, batch_size});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= IDLE;
            timer   <= '0;
            count   <= '0;
            fault_q <= 1'b0;
            start_d <= 1'b0;
        end else begin
            cur     <= nxt;
            timer   <= timer_nxt;
            count   <= count_nxt;
            fault_q <= fault_nxt;
            start_d <= start;
        end
    end

    always_comb begin
        nxt       = cur;
        timer_nxt = timer;
        fault_nxt = fault_q;
        inc       = 1'b0;
        if (estop) begin
            fault_nxt = 1'b1;
            nxt       = IDLE;
            timer_nxt = '0;
        end else begin
            if (clr_count) fault_nxt = 1'b0;
            if (cur == DONE) begin
                if (clr_count) nxt = IDLE;
            end else if (!auto_ok || stop) begin
                nxt       = IDLE;
                timer_nxt = '0;
            end else begin
                case (cur)
                    IDLE: begin
                        if (start_rise && !clr_count) begin
                            nxt       = DELAY;
                            timer_nxt = '0;
                        end
                    end
                    DELAY: begin
                        if (timer == DELAY_LAST) begin
                            nxt       = RUN;
                            timer_nxt = '0;
                        end else begin
                            timer_nxt = timer + TMR_W'(1);
                        end
                    end
                    RUN: begin
                        if (timer == RUN_LAST) begin
                            inc       = 1'b1;
                            timer_nxt = '0;
                            nxt       = batch_hit ? DONE : DELAY;
                        end else begin
                            timer_nxt = timer + TMR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        count_nxt = count;
        if (clr_count)
            count_nxt = '0;
        else if (inc && count != CNT_MAX)
            count_nxt = count + CNT_W'(1);
    end

    assign control = ~estop & ~fault_q &
                     (auto_ok ? (cur == RUN) : (man_ok & start & ~stop));
    assign busy        = (cur == DELAY) || (cur == RUN);
    assign batch_done  = (cur == DONE);
    assign state       = cur;
    assign cycle_count = count;
    assign fault       = fault_q;

endmodule

// File: tb/tb_lathe_cycle_seq.sv
// Bench for lathe_cycle_seq: per-cycle vector table through a scoreboard,
// plus directed sequences for estop, batch lowering, saturation and reset.
module tb_lathe_cycle_seq;

    logic       clk, rst;
    logic       start, stop, estop, auto_mode, man_mode, clr_count;
    logic [7:0] batch_size;
    logic       control, busy, batch_done, fault;
    logic [1:0] state;
    logic [7:0] cycle_count;

    int errors = 0;
    int checks = 0;

    lathe_cycle_seq #(
        .DELAY_TICKS(4),
        .RUN_TICKS  (3),
        .TMR_W      (4),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .estop      (estop),
        .auto_mode  (auto_mode),
        .man_mode   (man_mode),
        .clr_count  (clr_count),
        .batch_size (batch_size),
        .control    (control),
        .busy       (busy),
        .state      (state),
        .cycle_count(cycle_count),
        .batch_done (batch_done),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs {start,stop,estop,auto,man,clr}
    // expected {control,busy,state,count,batch_done,fault}
    typedef struct {
        logic [5:0]  in;
        logic [7:0]  bs;
        logic [13:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [13:0] exp_q[$];

    function automatic vec_t mk(input logic [5:0] in,
                                input logic c, input logic b,
                                input logic [1:0] s, input logic [7:0] n,
                                input logic d, input logic f);
        vec_t v;
        v.in  = in;
        v.bs  = 8'd2;
        v.exp = {c, b, s, n, d, f};
        return v;
    endfunction

    function automatic logic [13:0] outs();
        return {control, busy, state, cycle_count, batch_done, fault};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("wait_state_%0d", s), {30'd0, state}, {30'd0, s});
    endtask

    task automatic wait_count(input logic [7:0] c, input int budget);
        int n = 0;
        while (cycle_count !== c && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("wait_count_%0d", c), 32'(cycle_count), 32'(c));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear();
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
    endtask

    initial begin
        logic [13:0] e;
        rst = 1'b1;
        {start, stop, estop, man_mode, clr_count} = '0;
        auto_mode  = 1'b1;
        batch_size = 8'd2;
        #2;
        chk("reset_outs", 32'(outs()), 32'd0);
        tick();
        tick();
        chk("reset_hold", 32'(outs()), 32'd0);
        rst = 1'b0;

        // two-part batch, held start
        tbl.push_back(mk(6'b100100, 0,1,2'd1,8'd0,0,0));
        tbl.push_back(mk(6'b100100, 0,1,2'd1,8'd0,0,0));
        tbl.push_back(mk(6'b000100, 0,1,2'd1,8'd0,0,0));
        tbl.push_back(mk(6'b000100, 0,1,2'd1,8'd0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(6'b000100, 1,1,2'd2,8'd0,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(6'b000100, 0,1,2'd1,8'd1,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(6'b000100, 1,1,2'd2,8'd1,0,0));
        tbl.push_back(mk(6'b000100, 0,0,2'd3,8'd2,1,0));
        tbl.push_back(mk(6'b100100, 0,0,2'd3,8'd2,1,0));
        tbl.push_back(mk(6'b010000, 0,0,2'd3,8'd2,1,0));
        tbl.push_back(mk(6'b000101, 0,0,2'd0,8'd0,0,0));
        tbl.push_back(mk(6'b000100, 0,0,2'd0,8'd0,0,0));
        // stop on second RUN clock
        tbl.push_back(mk(6'b100100, 0,1,2'd1,8'd0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(6'b000100, 0,1,2'd1,8'd0,0,0));
        tbl.push_back(mk(6'b000100, 1,1,2'd2,8'd0,0,0));
        tbl.push_back(mk(6'b000100, 1,1,2'd2,8'd0,0,0));
        tbl.push_back(mk(6'b010100, 0,0,2'd0,8'd0,0,0));
        // start with stop, then held start gives no edge
        tbl.push_back(mk(6'b110100, 0,0,2'd0,8'd0,0,0));
        tbl.push_back(mk(6'b100100, 0,0,2'd0,8'd0,0,0));
        tbl.push_back(mk(6'b000100, 0,0,2'd0,8'd0,0,0));
        // MAN mode and illegal mode combinations
        tbl.push_back(mk(6'b100010, 1,0,2'd0,8'd0,0,0));
        tbl.push_back(mk(6'b110010, 0,0,2'd0,8'd0,0,0));
        tbl.push_back(mk(6'b000010, 0,0,2'd0,8'd0,0,0));
        tbl.push_back(mk(6'b100110, 0,0,2'd0,8'd0,0,0));
        tbl.push_back(mk(6'b100000, 0,0,2'd0,8'd0,0,0));
        tbl.push_back(mk(6'b000100, 0,0,2'd0,8'd0,0,0));
        // AUTO -> MAN during RUN aborts without counting
        tbl.push_back(mk(6'b100100, 0,1,2'd1,8'd0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(6'b000100, 0,1,2'd1,8'd0,0,0));
        tbl.push_back(mk(6'b000100, 1,1,2'd2,8'd0,0,0));
        tbl.push_back(mk(6'b000010, 0,0,2'd0,8'd0,0,0));
        // estop in DELAY, fault latch and clear
        tbl.push_back(mk(6'b100100, 0,1,2'd1,8'd0,0,0));
        tbl.push_back(mk(6'b000100, 0,1,2'd1,8'd0,0,0));
        tbl.push_back(mk(6'b001100, 0,0,2'd0,8'd0,0,1));
        tbl.push_back(mk(6'b001101, 0,0,2'd0,8'd0,0,1));
        tbl.push_back(mk(6'b100100, 0,0,2'd0,8'd0,0,1));
        tbl.push_back(mk(6'b000101, 0,0,2'd0,8'd0,0,0));
        tbl.push_back(mk(6'b100100, 0,1,2'd1,8'd0,0,0));
        tbl.push_back(mk(6'b010100, 0,0,2'd0,8'd0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            {start, stop, estop, auto_mode, man_mode, clr_count} = tbl[i].in;
            batch_size = tbl[i].bs;
            exp_q.push_back(tbl[i].exp);
            tick();
            e = exp_q.pop_front();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(e));
        end
        {start, stop, estop, man_mode, clr_count} = '0;
        auto_mode = 1'b1;

        // estop drops control before any clock edge
        pulse_start();
        wait_state(2'd2, 10);
        chk("run_control", 32'(control), 32'd1);
        estop = 1'b1;
        #1;
        chk("estop_comb", 32'(control), 32'd0);
        tick();
        chk("estop_fault", 32'({fault, state}), 32'h4);
        estop = 1'b0;
        clear();
        chk("fault_clr", 32'(fault), 32'd0);

        // lowering batch_size below the count finishes on next part
        batch_size = 8'd0;
        tick();
        pulse_start();
        wait_count(8'd2, 40);
        batch_size = 8'd1;
        wait_state(2'd3, 20);
        chk("lowered_cnt", 32'(cycle_count), 32'd3);
        chk("lowered_done", 32'(batch_done), 32'd1);
        clear();
        chk("lowered_clr", 32'(state), 32'd0);

        // unlimited batch saturates at 255
        batch_size = 8'd0;
        pulse_start();
        wait_count(8'd255, 2000);
        repeat (20) tick();
        chk("sat_cnt", 32'(cycle_count), 32'd255);
        chk("sat_busy", 32'({busy, batch_done}), 32'h2);

        // async reset mid-RUN
        wait_state(2'd2, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", 32'(outs()), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_after", 32'(outs()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
